// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the car-racing display pipeline: screen-state
// encoding, colour constants, screen geometry and game-rule defaults. Imported
// by the game-flow sequencer, the pixel mux, the dtg and the image blocks.
// -----------------------------------------------------------------------------
package game_pkg;

  // Screen state encoding; the numeric values are visible on state_out.
  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_t;

  // 12-bit colours, packed {blue, green, red}.
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

  // Visible screen geometry.
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int LAST_ROW_DEF = SCREEN_H - 1;
  localparam int LAST_COL_DEF = SCREEN_W - 1;

  // Game rule defaults.
  localparam int WIN_SCORE_DEF   = 50;
  localparam int HOLD_FRAMES_DEF = 180;

  // Overlay compositing: black overlay pixels are transparent and let the
  // underlying layer show through.
  function automatic logic [11:0] overlay_pick(input logic [11:0] ovl,
                                               input logic [11:0] base);
    return (ovl != BLACK) ? ovl : base;
  endfunction

endpackage

// File: rtl/game_screen_ctrl_screen_mux.sv
// -----------------------------------------------------------------------------
// screen_mux
// Registered final pixel select. Chooses the title overlay, the game layer,
// or the win/lose overlay composited over the frozen game layer, and blanks
// to black outside the visible region. One clock of latency.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-high reset (output forced black)
//   video_on_i   visible-region flag, aligned with the pixel inputs
//   state_i      screen state that applies to this pixel
//   game_pix_i   game layer pixel
//   win_pix_i    win overlay pixel (black = transparent)
//   lose_pix_i   lose overlay pixel (black = transparent)
//   title_pix_i  title overlay pixel
//   pix_o        registered output pixel
// -----------------------------------------------------------------------------
module screen_mux
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        video_on_i,
  input  state_t      state_i,
  input  logic [11:0] game_pix_i,
  input  logic [11:0] win_pix_i,
  input  logic [11:0] lose_pix_i,
  input  logic [11:0] title_pix_i,
  output logic [11:0] pix_o
);

  logic [11:0] pix_d;
  logic [11:0] pix_q;

  always_comb begin
    pix_d = BLACK;
    if (video_on_i) begin
      unique case (state_i)
        ST_TITLE: pix_d = title_pix_i;
        ST_PLAY:  pix_d = game_pix_i;
        ST_WIN:   pix_d = overlay_pick(win_pix_i, game_pix_i);
        ST_LOSE:  pix_d = overlay_pick(lose_pix_i, game_pix_i);
        default:  pix_d = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= BLACK;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// -----------------------------------------------------------------------------
// game_screen_ctrl
// Game-flow sequencer. Owns the screen state (title, play, win, lose), keeps
// the car/score logic in reset outside of play, changes state only at frame
// boundaries and drives the final registered pixel mux.
//
// Parameters:
//   WIN_SCORE    score at or above which play ends in a win
//   HOLD_FRAMES  frames the win/lose screen is held (1..255)
//   LAST_ROW     final visible row of a frame
//   LAST_COL     final visible column of a frame
//
// Ports:
//   clk         pixel clock, all logic on rising edge
//   reset       asynchronous active-high reset
//   pix_row     current pixel row from dtg
//   pix_col     current pixel column from dtg
//   video_on    visible-region flag from dtg
//   start_btn   debounced start button (level)
//   crash_in    collision flag from moving cars (level or pulse)
//   score_in    current score from moving cars
//   game_pix    game layer pixel
//   win_pix     win overlay pixel
//   lose_pix    lose overlay pixel
//   title_pix   title overlay pixel
//   game_reset  high outside PLAY, holds car/score logic in reset
//   game_run    high only in PLAY
//   state_out   current state encoding
//   frame_tick  one-cycle pulse the cycle after the last visible pixel
//   pix_out     selected pixel, {blue, green, red}
// -----------------------------------------------------------------------------
module game_screen_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int LAST_ROW    = LAST_ROW_DEF,
  parameter int LAST_COL    = LAST_COL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_row,
  input  logic [9:0]  pix_col,
  input  logic        video_on,
  input  logic        start_btn,
  input  logic        crash_in,
  input  logic [5:0]  score_in,
  input  logic [11:0] game_pix,
  input  logic [11:0] win_pix,
  input  logic [11:0] lose_pix,
  input  logic [11:0] title_pix,
  output logic        game_reset,
  output logic        game_run,
  output logic [1:0]  state_out,
  output logic        frame_tick,
  output logic [11:0] pix_out
);

  localparam logic [9:0] LAST_ROW_C  = 10'(LAST_ROW);
  localparam logic [9:0] LAST_COL_C  = 10'(LAST_COL);
  localparam logic [5:0] WIN_SCORE_C = 6'(WIN_SCORE);
  localparam logic [7:0] HOLD_LAST_C = 8'(HOLD_FRAMES - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       frame_tick_q, frame_tick_d;
  logic       start_dly_q;
  logic       start_pend_q, start_pend_d;
  logic       win_pend_q, win_pend_d;
  logic       lose_pend_q, lose_pend_d;
  logic       game_reset_q, game_run_q;

  logic start_rise;
  logic start_evt, win_evt, lose_evt;
  logic start_seen, win_seen, lose_seen;

  // The delayed copy resets to 1 so a button held through reset is not
  // mistaken for a fresh press.
  assign start_rise = start_btn & ~start_dly_q;

  // Events are qualified by the state they are meaningful in; presses outside
  // TITLE are dropped rather than queued.
  assign start_evt = (state_q == ST_TITLE) & start_rise;
  assign win_evt   = (state_q == ST_PLAY) & (score_in >= WIN_SCORE_C);
  assign lose_evt  = (state_q == ST_PLAY) & crash_in;

  // Latched view including the current cycle, so an event coinciding with
  // frame_tick still counts toward that tick.
  assign start_seen = start_pend_q | start_evt;
  assign win_seen   = win_pend_q   | win_evt;
  assign lose_seen  = lose_pend_q  | lose_evt;

  always_comb begin
    frame_tick_d = (pix_row == LAST_ROW_C) && (pix_col == LAST_COL_C);

    // Latches accumulate within a frame and are consumed by each tick.
    start_pend_d = frame_tick_q ? 1'b0 : start_seen;
    win_pend_d   = frame_tick_q ? 1'b0 : win_seen;
    lose_pend_d  = frame_tick_q ? 1'b0 : lose_seen;

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      ST_TITLE: begin
        hold_cnt_d = 8'd0;
        if (frame_tick_q && start_seen) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        hold_cnt_d = 8'd0;
        if (frame_tick_q) begin
          // Win takes priority over a crash in the same frame.
          if (win_seen) begin
            state_d = ST_WIN;
          end else if (lose_seen) begin
            state_d = ST_LOSE;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (frame_tick_q) begin
          if (hold_cnt_q == HOLD_LAST_C) begin
            state_d    = ST_TITLE;
            hold_cnt_d = 8'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d    = ST_TITLE;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_TITLE;
      hold_cnt_q   <= 8'd0;
      frame_tick_q <= 1'b0;
      start_dly_q  <= 1'b1;
      start_pend_q <= 1'b0;
      win_pend_q   <= 1'b0;
      lose_pend_q  <= 1'b0;
      game_reset_q <= 1'b1;
      game_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      frame_tick_q <= frame_tick_d;
      start_dly_q  <= start_btn;
      start_pend_q <= start_pend_d;
      win_pend_q   <= win_pend_d;
      lose_pend_q  <= lose_pend_d;
      // Registered from next state so they move on the same edge as state_out.
      game_reset_q <= (state_d != ST_PLAY);
      game_run_q   <= (state_d == ST_PLAY);
    end
  end

  // The mux is fed the next state so the pixel sampled during the tick cycle
  // (the first pixel after the frame boundary) already uses the new screen.
  screen_mux u_screen_mux (
    .clk         (clk),
    .rst         (reset),
    .video_on_i  (video_on),
    .state_i     (state_d),
    .game_pix_i  (game_pix),
    .win_pix_i   (win_pix),
    .lose_pix_i  (lose_pix),
    .title_pix_i (title_pix),
    .pix_o       (pix_out)
  );

  assign state_out  = state_q;
  assign frame_tick = frame_tick_q;
  assign game_reset = game_reset_q;
  assign game_run   = game_run_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_screen_ctrl
// Drives a shrunken raster (8 columns x 5 rows, 6x4 visible) so that the full
// 180-frame hold fits in a short run. A game-flow reference model predicts the
// outputs after every clock edge and queues them; a monitor on the falling
// edge pops and compares.
// -----------------------------------------------------------------------------
module tb_game_screen_ctrl;

  localparam int WIN_SCORE = 50;
  localparam int HOLD      = 180;
  localparam int LROW      = 3;
  localparam int LCOL      = 5;
  localparam int HTOT      = 8;
  localparam int VTOT      = 5;
  localparam int FRAME     = HTOT * VTOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_row = 10'd0;
  logic [9:0]  pix_col = 10'd0;
  logic        video_on = 1'b1;
  logic        start_btn = 1'b1;
  logic        crash_in = 1'b0;
  logic [5:0]  score_in = 6'd0;
  logic [11:0] game_pix = 12'h000;
  logic [11:0] win_pix = 12'h000;
  logic [11:0] lose_pix = 12'h000;
  logic [11:0] title_pix = 12'h000;
  logic        game_reset, game_run, frame_tick;
  logic [1:0]  state_out;
  logic [11:0] pix_out;

  always #5 clk = ~clk;

  game_screen_ctrl #(
    .WIN_SCORE(WIN_SCORE), .HOLD_FRAMES(HOLD), .LAST_ROW(LROW), .LAST_COL(LCOL)
  ) dut (
    .clk(clk), .reset(reset), .pix_row(pix_row), .pix_col(pix_col),
    .video_on(video_on), .start_btn(start_btn), .crash_in(crash_in),
    .score_in(score_in), .game_pix(game_pix), .win_pix(win_pix),
    .lose_pix(lose_pix), .title_pix(title_pix), .game_reset(game_reset),
    .game_run(game_run), .state_out(state_out), .frame_tick(frame_tick),
    .pix_out(pix_out)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        grst;
    logic        grun;
    logic        ftick;
    logic [11:0] pix;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t reset_exp();
    exp_t e;
    e.st = 2'd0; e.grst = 1'b1; e.grun = 1'b0; e.ftick = 1'b0; e.pix = 12'h000;
    return e;
  endfunction

  task automatic check(input exp_t e, input string name);
    vectors++;
    if (state_out !== e.st || game_reset !== e.grst || game_run !== e.grun ||
        frame_tick !== e.ftick || pix_out !== e.pix) begin
      miscompares++;
      $display("FAIL %s t=%0t: got st=%0d rst=%0b run=%0b tick=%0b pix=%h, required st=%0d rst=%0b run=%0b tick=%0b pix=%h",
               name, $time, state_out, game_reset, game_run, frame_tick, pix_out,
               e.st, e.grst, e.grun, e.ftick, e.pix);
    end
  endtask

  // ---------------- reference model: game rules per clock edge -------------
  // screen: 0 title, 1 play, 2 win, 3 lose. Flags record what happened during
  // the current frame; a frame boundary decides the next screen.
  int   m_screen, m_next, m_held;
  bit   m_tick, m_prev_btn, m_started, m_won, m_crashed;
  exp_t m_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_screen = 0; m_held = 0; m_tick = 0; m_prev_btn = 1;
      m_started = 0; m_won = 0; m_crashed = 0;
      sb.delete();
    end else begin
      if (m_screen == 0 && start_btn && !m_prev_btn) m_started = 1;
      if (m_screen == 1 && int'(score_in) >= WIN_SCORE) m_won = 1;
      if (m_screen == 1 && crash_in) m_crashed = 1;
      m_prev_btn = start_btn;
      m_next = m_screen;
      if (m_tick) begin
        if (m_screen == 0) begin
          if (m_started) m_next = 1;
        end else if (m_screen == 1) begin
          if (m_won) m_next = 2;
          else if (m_crashed) m_next = 3;
        end else begin
          m_held = m_held + 1;
          if (m_held == HOLD) m_next = 0;
        end
        m_started = 0; m_won = 0; m_crashed = 0;
      end
      if (m_next != m_screen) begin
        $display("t=%0t screen %0d -> %0d", $time, m_screen, m_next);
        m_held = 0;
      end
      m_screen = m_next;
      if (!video_on)          m_e.pix = 12'h000;
      else if (m_screen == 0) m_e.pix = title_pix;
      else if (m_screen == 1) m_e.pix = game_pix;
      else if (m_screen == 2) m_e.pix = (win_pix != 0) ? win_pix : game_pix;
      else                    m_e.pix = (lose_pix != 0) ? lose_pix : game_pix;
      m_e.st    = 2'(m_screen);
      m_e.grst  = (m_screen != 1);
      m_e.grun  = (m_screen == 1);
      m_e.ftick = (int'(pix_row) == LROW) && (int'(pix_col) == LCOL);
      m_tick = m_e.ftick;
      sb.push_back(m_e);
    end
  end

  // ---------------- monitor ------------------------------------------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset || sb.size() == 0) mon_e = reset_exp();
    else                         mon_e = sb.pop_front();
    check(mon_e, "cycle");
  end

  // ---------------- stimulus helpers --------------------------------------
  int  r_cnt = 0, c_cnt = 0;
  bit  rand_pix = 1;

  task automatic step();
    @(posedge clk);
    #1;
    if (c_cnt == HTOT - 1) begin
      c_cnt = 0;
      r_cnt = (r_cnt == VTOT - 1) ? 0 : r_cnt + 1;
    end else begin
      c_cnt++;
    end
    pix_col  = 10'(c_cnt);
    pix_row  = 10'(r_cnt);
    video_on = (c_cnt <= LCOL) && (r_cnt <= LROW);
    if (rand_pix) begin
      game_pix  = 12'($urandom);
      title_pix = 12'($urandom);
      win_pix   = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
      lose_pix  = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    run_cycles(3);
    start_btn = 1'b0;
    step();
  endtask

  task automatic expect_state(input logic [1:0] tgt, input string name);
    vectors++;
    if (state_out !== tgt) begin
      miscompares++;
      $display("FAIL %s: state_out=%0d required %0d", name, state_out, tgt);
    end else begin
      $display("check %s: state %0d", name, tgt);
    end
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int max_cycles, input string name);
    int n = 0;
    while (state_out !== tgt && n < max_cycles) begin
      step();
      n++;
    end
    vectors++;
    if (state_out !== tgt) begin
      miscompares++;
      $display("FAIL %s: state_out=%0d required %0d within %0d cycles", name, state_out, tgt, max_cycles);
    end else begin
      $display("wait %s: state %0d after %0d cycles", name, tgt, n);
    end
  endtask

  task automatic step_until_row(input int row);
    int n = 0;
    while (r_cnt != row && n < FRAME) begin
      step();
      n++;
    end
  endtask

  task automatic check_pix(input logic [11:0] req, input string name);
    vectors++;
    if (pix_out !== req) begin
      miscompares++;
      $display("FAIL %s: pix_out=%h required %h", name, pix_out, req);
    end else begin
      $display("check %s: pix %h", name, req);
    end
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    // Reset with the button held, then release reset with it still held.
    run_cycles(4);
    reset = 1'b0;
    run_cycles(3 * FRAME);
    expect_state(2'd0, "held_btn_no_play");
    start_btn = 1'b0;
    run_cycles(2 * FRAME);
    expect_state(2'd0, "idle_title");
    press_start();
    wait_state(2'd1, 2 * FRAME, "press_to_play");

    // Play with sub-threshold scores, then reach the win score mid-frame.
    repeat (3 * FRAME) begin
      step();
      score_in = 6'($urandom_range(0, WIN_SCORE - 1));
    end
    step_until_row(1);
    score_in = 6'(WIN_SCORE);
    wait_state(2'd2, 2 * FRAME, "score_win");
    score_in = 6'd0;

    // Pixel mux in WIN with fixed layer values at a visible pixel.
    rand_pix = 0;
    step_until_row(0);
    game_pix = 12'hABC; win_pix = 12'h000;
    step();
    check_pix(12'hABC, "win_transparent");
    win_pix = 12'hFFF;
    step();
    check_pix(12'hFFF, "win_overlay");
    video_on = 1'b0;
    step();
    check_pix(12'h000, "blanking");
    rand_pix = 1;

    wait_state(2'd0, (HOLD + 2) * FRAME, "win_hold_expire");

    // Single-cycle crash pulse leads to LOSE; a press in LOSE is ignored.
    press_start();
    wait_state(2'd1, 2 * FRAME, "play_for_crash");
    step_until_row(1);
    crash_in = 1'b1;
    step();
    crash_in = 1'b0;
    wait_state(2'd3, 2 * FRAME, "crash_lose");
    run_cycles(5 * FRAME);
    press_start();
    expect_state(2'd3, "press_in_lose");
    wait_state(2'd0, (HOLD + 2) * FRAME, "lose_hold_expire");
    run_cycles(3 * FRAME);
    expect_state(2'd0, "title_after_lose");

    // Crash and win score in the same frame: win has priority.
    press_start();
    wait_state(2'd1, 2 * FRAME, "play_for_both");
    step_until_row(1);
    crash_in = 1'b1;
    step();
    crash_in = 1'b0;
    score_in = 6'(WIN_SCORE);
    step();
    score_in = 6'd0;
    wait_state(2'd2, 2 * FRAME, "win_over_crash");

    // Asynchronous reset mid-frame during WIN.
    run_cycles(10 * FRAME);
    step_until_row(2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check(reset_exp(), "async_reset");
    step();
    reset = 1'b0;
    step();
    expect_state(2'd0, "after_async_reset");

    // Fresh WIN after reset must hold the full count again.
    press_start();
    wait_state(2'd1, 2 * FRAME, "play_after_reset");
    score_in = 6'd63;
    step();
    score_in = 6'd0;
    wait_state(2'd2, 2 * FRAME, "wrap_score_win");
    wait_state(2'd0, (HOLD + 2) * FRAME, "second_win_hold");

    // Randomized play.
    repeat (3000) begin
      step();
      start_btn = ($urandom_range(0, 15) == 0);
      crash_in  = ($urandom_range(0, 150) == 0);
      score_in  = ($urandom_range(0, 200) == 0) ? 6'($urandom_range(WIN_SCORE, 63))
                                                : 6'($urandom_range(0, WIN_SCORE - 1));
    end
    run_cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

endmodule
